// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage definitions: occupancy encoding, per-stage control widths
// and the all-zero bubble encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // Control bundle widths of the existing stage boundaries
    localparam int IFID_CTRL_W  = 8;
    localparam int IDEX_CTRL_W  = 8;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_CTRL_W = 8;  // RegRd 5, RegWrite 1, MemtoReg 2

    // A bubble is all zeros: nop instruction, RegWrite = 0
    localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle seen by one pipeline stage: upstream side (in_*)
// and downstream side (out_*).
interface pipe_stage_skid_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter; sticks at all-ones and is cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] value_r;

    // Count qualifying events until the maximum value is reached
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_r <= {CNT_W{1'b0}};
        end else if (inc && (value_r != CNT_MAX)) begin
            value_r <= value_r + CNT_ONE;
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with a one-entry skid buffer so that in_ready is a
// pure flop, plus synchronous flush and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int CTRL_W     = 8,
    parameter int CNT_W      = 16,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_skid_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [DATA_W-1:0] NOP_DATA = {DATA_W{NOP_BIT}};
    localparam logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{NOP_BIT}};

    occ_e              state_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;

    logic accept_s;
    logic pop_s;
    logic stall_s;

    assign accept_s = bus.in_valid && in_ready_r;
    assign pop_s    = out_valid_r && bus.out_ready;
    assign stall_s  = out_valid_r && !bus.out_ready;

    // Occupancy FSM with main/skid storage; flush overrides every transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            main_data_r <= NOP_DATA;
            main_ctrl_r <= NOP_CTRL;
            skid_data_r <= NOP_DATA;
            skid_ctrl_r <= NOP_CTRL;
        end else if (flush) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            main_ctrl_r <= NOP_CTRL;
            skid_ctrl_r <= NOP_CTRL;
            if (CLEAR_DATA) begin
                main_data_r <= NOP_DATA;
                skid_data_r <= NOP_DATA;
            end else begin
                main_data_r <= main_data_r;
                skid_data_r <= skid_data_r;
            end
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_r     <= ONE;
                        out_valid_r <= 1'b1;
                        main_data_r <= bus.in_data;
                        main_ctrl_r <= bus.in_ctrl;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && pop_s) begin
                        main_data_r <= bus.in_data;
                        main_ctrl_r <= bus.in_ctrl;
                    end else if (accept_s) begin
                        state_r     <= FULL;
                        in_ready_r  <= 1'b0;
                        skid_data_r <= bus.in_data;
                        skid_ctrl_r <= bus.in_ctrl;
                    end else if (pop_s) begin
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                        main_ctrl_r <= NOP_CTRL;
                        if (CLEAR_DATA) begin
                            main_data_r <= NOP_DATA;
                        end else begin
                            main_data_r <= main_data_r;
                        end
                    end else begin
                        state_r <= ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move the state
                    if (pop_s) begin
                        state_r     <= ONE;
                        in_ready_r  <= 1'b1;
                        main_data_r <= skid_data_r;
                        main_ctrl_r <= skid_ctrl_r;
                        skid_ctrl_r <= NOP_CTRL;
                        if (CLEAR_DATA) begin
                            skid_data_r <= NOP_DATA;
                        end else begin
                            skid_data_r <= skid_data_r;
                        end
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    main_ctrl_r <= NOP_CTRL;
                    skid_ctrl_r <= NOP_CTRL;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_s),
        .value (stall_cnt)
    );

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = main_data_r;
    assign bus.out_ctrl  = main_ctrl_r & {CTRL_W{out_valid_r}};
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic, parametrised pipeline-stage register that replaces the per-stage hand-written boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a data bundle plus a control bundle between stages using valid/ready handshakes. A one-entry skid buffer breaks the combinational stall path, so `in_ready` is purely registered. Also provides synchronous flush and a saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_W, 128, width of the data bundle (instruction, PC+4, ALU result, memory data, ...).
- CTRL_W, 8, width of the control bundle (RegRd, RegWrite, MemtoReg, ...).
- CNT_W, 16, width of the stall counter.
- CLEAR_DATA, 1: when 1, data registers are zeroed on flush and on drain to empty; when 0, data holds and only valid/ctrl clear.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous kill of all held and incoming contents.
- in_valid, input, 1: upstream stage presents an entry.
- in_ready, output, 1: stage can accept; registered, equals !skid_valid.
- in_data, input, DATA_W: upstream data bundle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- out_valid, output, 1: entry presented downstream.
- out_ready, input, 1: downstream accepts (0 = downstream stall).
- out_data, output, DATA_W: held data bundle.
- out_ctrl, output, CTRL_W: held control bundle; forced to 0 whenever out_valid = 0.
- stall_cnt, output, CNT_W: cycles with out_valid && !out_ready, saturating.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Occupancy states: EMPTY (0), ONE (main valid), FULL (main + skid valid).
- Reset (rst = 0, asynchronous): both valids = 0; out_data = 0; out_ctrl = 0; skid registers = 0; stall_cnt = 0; in_ready = 1 after release.
- Handshake definitions: accept = in_valid && in_ready; pop = out_valid && out_ready.
- EMPTY:
  - accept -> ONE, main <= input.
- ONE:
  - accept && pop -> ONE, main <= input.
  - accept && !pop -> FULL, skid <= input.
  - pop && !accept -> EMPTY.
- FULL (in_ready = 0, no accept possible):
  - pop -> ONE, main <= skid, skid cleared.
- Latency and ordering: one cycle from accept to out_valid; throughput is one entry per cycle when out_ready is held at 1; strict FIFO order.
- flush (highest priority, synchronous): next state EMPTY and both valids = 0. Same-cycle in_valid is dropped and does not count as accepted, even though in_ready may be 1. Same-cycle pop is still seen downstream for the current cycle. With CLEAR_DATA = 1, all data and ctrl registers become 0, matching the existing bubble encoding (all-zero = nop, RegWrite = 0).
- out_ctrl gating: out_ctrl = main_ctrl & {CTRL_W{out_valid}}, so a bubble can never assert write-enable.
- stall_cnt: increments when out_valid && !out_ready, saturates at 2^CNT_W − 1, is unaffected by flush, and is cleared only by rst.
- Reset mid-operation: all entries are discarded immediately, with no partial handshake.
- Prohibited inputs: in_data / in_ctrl changing while in_valid && !in_ready is legal, since nothing is captured in that case.

Decomposition:
- Shared package `pipe_pkg`:
  - occupancy state enum {EMPTY, ONE, FULL};
  - per-stage CTRL_W constants (e.g. MEMWB_CTRL_W = 8: RegRd 5, RegWrite 1, MemtoReg 2);
  - NOP bundle constant = 0.
- Optional sub-module `sat_counter` (CNT_W, inc, value) for the stall counter, reusable by other performance counters.

Test Plan:
- Reset/pass-through: rst low then high; out_ready = 1; drive in_valid = 1 with data 0x1, 0x2, 0x3 on consecutive cycles -> out_data 0x1, 0x2, 0x3 one cycle later each; in_ready stays 1; stall_cnt = 0.
- Stall into skid: entry 0xA accepted, out_ready = 0, then 0xB offered -> FULL, in_ready = 0 next cycle, 0xC is held off. Raise out_ready -> outputs 0xA, 0xB, 0xC in order with no loss or duplication; stall_cnt equals the stalled cycles (e.g. 3).
- Flush in FULL with in_valid = 1 carrying 0xD -> next cycle out_valid = 0, out_ctrl = 0, out_data = 0, in_ready = 1; 0xD never appears downstream.
- Ctrl gating: ctrl 0xFF accepted and then popped with no new input -> out_valid = 0 and out_ctrl = 0x00 on the following cycle.
- Saturation: CNT_W = 4, hold out_valid = 1 and out_ready = 0 for 20 cycles -> stall_cnt = 15 and stays there; a flush does not clear it.
- Async reset mid-FULL: rst asserted between clock edges -> outputs are zero immediately, without waiting for a clock edge; after release the stage is EMPTY and in_ready = 1.
